pipeline_stage_reg: RTL and testbench
=====================================

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 96, payload bits per entry (1..512).
REQ-002 SHALL have parameter DEPTH, default 2, storage entries (1..8, non-power-of-two legal).
REQ-003 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream stage presents an entry.
REQ-006 SHALL have port in_data  input  WIDTH  upstream payload (pc+4, instruction, control, data fields packed).
REQ-007 SHALL have port in_halt  input  1  entry carries a halt marker.
REQ-008 SHALL have port in_ready  output  1  stage accepts an entry this cycle.
REQ-009 SHALL have port out_valid  output  1  head entry present.
REQ-010 SHALL have port out_data  output  WIDTH  head payload.
REQ-011 SHALL have port out_ready  input  1  downstream consumes head this cycle.
REQ-012 SHALL have port flush  input  1  synchronous squash of all held entries.
REQ-013 SHALL have port halt  output  1  sticky: a halt-marked entry has left the stage.
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 SHALL push when in_valid && in_ready; pop when out_valid && out_ready; both in one cycle allowed.
REQ-016 SHALL drive in_ready = (count < DEPTH), from registered state only; no combinational path from out_ready to in_ready.
REQ-017 SHALL drive out_valid = (count != 0), out_data = entry at read pointer, both from registers only.
REQ-018 SHALL present a pushed entry at out_data one cycle after the push edge when previously empty (latency 1).
REQ-019 SHALL update count: +1 push only, -1 pop only, unchanged on both or neither.
REQ-020 SHALL wrap read/write pointers from DEPTH-1 to 0, correct for any DEPTH.
REQ-021 SHALL preserve entry order (FIFO); held entries stable while out_ready low.
REQ-022 SHALL on flush set count, pointers to 0 next edge; push and pop in the same cycle are discarded; flush has priority over all.
REQ-023 SHALL set halt on the edge where a halt-marked entry pops; halt stays 1 until reset (flush does not clear it).
REQ-024 SHALL not set halt for halt-marked entries removed by flush.
REQ-025 SHALL ignore in_data/in_halt when in_valid low or in_ready low.

Reset
REQ-026 SHALL on RST asserted, asynchronously: count=0, pointers=0, out_valid=0, in_ready=1, halt=0, perf counters=0.
REQ-027 SHALL drive out_data to 0 after reset until first push (storage cleared).
REQ-028 SHALL on reset mid-operation drop all entries; first push after release behaves as from empty.

Configuration
REQ-029 SHALL with PIPEREG_PERF_EN defined add outputs stall_cycles (32) and occupancy_hwm ($clog2(DEPTH+1)).
REQ-030 SHALL with PIPEREG_PERF_EN count stall_cycles each cycle in_valid && !in_ready, saturating at 32'hFFFFFFFF.
REQ-031 SHALL with PIPEREG_PERF_EN track occupancy_hwm as maximum count reached; flush clears neither counter.
REQ-032 SHALL without PIPEREG_PERF_EN omit both ports and their logic; all other behaviour identical.

Verification (WIDTH=32, DEPTH=2)
REQ-033 SHALL cover: push 0xAAAA0001 into empty, out_ready=1 -> out_valid=1, out_data=0xAAAA0001 next cycle, count back to 0 after pop.
REQ-034 SHALL cover: out_ready=0, push 0x1,0x2,0x3 back-to-back -> 0x1,0x2 accepted, in_ready=0, count=2; 0x3 accepted after one pop; output order 0x1,0x2,0x3.
REQ-035 SHALL cover: full, simultaneous push 0x5 and pop -> no push (in_ready=0), count=1; then push/pop same cycle at count=1 -> count stays 1, 6 pushes wrap pointers with order intact.
REQ-036 SHALL cover: count=2 with halt-marked head, flush=1 -> count=0 next edge, halt stays 0; then halt entry pushed and popped -> halt=1, remains 1 after a later flush.
REQ-037 SHALL cover: RST pulsed asynchronously mid-cycle at count=2 -> out_valid=0, in_ready=1, count=0 immediately, halt=0.
REQ-038 SHALL cover (PIPEREG_PERF_EN): hold full with in_valid=1 for 10 cycles -> stall_cycles=10, occupancy_hwm=2; flush leaves both unchanged.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// Elastic pipeline register: DEPTH-entry FIFO with flush and sticky halt.
// Define PIPEREG_PERF_EN to add stall_cycles and occupancy_hwm outputs.
module pipeline_stage_reg #(
  parameter int WIDTH = 96,
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_halt,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic             halt,
  output logic [CW-1:0]    count
`ifdef PIPEREG_PERF_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [CW-1:0]    occupancy_hwm
`endif
);

  logic [WIDTH:0]  mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            halt_q, halt_d;
  logic            push, pop;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = count_q < CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign out_data  = mem_q[rd_ptr_q][WIDTH-1:0];
  assign halt      = halt_q;
  assign count     = count_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Flush discards both the push and the pop, so a squashed halt never fires.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    halt_d   = halt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = inc(wr_ptr_q);
      if (pop) begin
        rd_ptr_d = inc(rd_ptr_q);
        halt_d   = halt_q | mem_q[rd_ptr_q][WIDTH];
      end
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      halt_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      halt_q   <= halt_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !flush) begin
      mem_q[wr_ptr_q] <= {in_halt, in_data};
    end
  end

`ifdef PIPEREG_PERF_EN
  logic [31:0]   stall_q, stall_d;
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    stall_d = stall_q;
    hwm_d   = hwm_q;
    if (in_valid && !in_ready && stall_q != '1) stall_d = stall_q + 32'd1;
    if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
      hwm_q   <= '0;
    end else begin
      stall_q <= stall_d;
      hwm_q   <= hwm_d;
    end
  end

  assign stall_cycles  = stall_q;
  assign occupancy_hwm = hwm_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench for pipeline_stage_reg (WIDTH=32, DEPTH=2).
// Stimulus pushes expected payloads; a negedge monitor checks pops.
module tb_pipeline_stage_reg;

  localparam int W  = 32;
  localparam int D  = 2;
  localparam int CW = $clog2(D + 1);

  logic          CLK;
  logic          RST;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_halt;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          flush;
  logic          halt;
  logic [CW-1:0] count;
`ifdef PIPEREG_PERF_EN
  logic [31:0]   stall_cycles;
  logic [CW-1:0] occupancy_hwm;
`endif

  int tests = 0;
  int fails = 0;
  logic [W-1:0] sb [$];
  logic [W-1:0] exp_v;

  pipeline_stage_reg #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_data(in_data),
    .in_halt(in_halt), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .flush(flush),
    .halt(halt), .count(count)
`ifdef PIPEREG_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .occupancy_hwm(occupancy_hwm)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: inputs are stable at negedge, so this sees what the next edge acts on.
  always @(negedge CLK) begin
    if (!RST) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL pop_unexpected: got %h, queue empty", out_data);
          end else begin
            exp_v = sb.pop_front();
            if (out_data !== exp_v) begin
              fails++;
              $display("FAIL pop_order: got %h expected %h", out_data, exp_v);
            end
          end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic h,
                       input logic r, input logic f);
    in_valid = v; in_data = d; in_halt = h; out_ready = r; flush = f;
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    RST = 1'b1;
    in_valid = 0; in_data = '0; in_halt = 0; out_ready = 0; flush = 0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_halt", 32'(halt), 0);
    check("rst_out_data", out_data, 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // single entry, latency 1
    drive(1, 32'hAAAA0001, 0, 1, 0);
    check("lat_valid", 32'(out_valid), 1);
    check("lat_data", out_data, 32'hAAAA0001);
    check("lat_count", 32'(count), 1);
    drive(0, '0, 0, 1, 0);
    check("lat_drain", 32'(count), 0);

    // backpressure
    drive(1, 32'h1, 0, 0, 0);
    check("bp_count1", 32'(count), 1);
    drive(1, 32'h2, 0, 0, 0);
    check("bp_count2", 32'(count), 2);
    check("bp_full_ready", 32'(in_ready), 0);
    drive(1, 32'h3, 0, 0, 0);
    check("bp_held", out_data, 32'h1);
    drive(1, 32'h3, 0, 1, 0);
    check("bp_pop_count", 32'(count), 1);
    drive(1, 32'h3, 0, 0, 0);
    check("bp_push3", 32'(count), 2);
    drive(0, '0, 0, 1, 0);
    drive(0, '0, 0, 1, 0);
    check("bp_empty", 32'(count), 0);

    // full with simultaneous push/pop, then pointer wrap at count=1
    drive(1, 32'h10, 0, 0, 0);
    drive(1, 32'h11, 0, 0, 0);
    drive(1, 32'h5, 0, 1, 0);
    check("full_pp_count", 32'(count), 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h20 + 32'(i), 0, 1, 0);
      check("wrap_count", 32'(count), 1);
    end
    drive(0, '0, 0, 1, 0);
    check("wrap_empty", 32'(count), 0);

    // flush drops halt-marked entries
    drive(1, 32'h30, 1, 0, 0);
    drive(1, 32'h31, 0, 0, 0);
    check("fl_count2", 32'(count), 2);
    drive(0, '0, 0, 0, 1);
    check("fl_count0", 32'(count), 0);
    check("fl_valid", 32'(out_valid), 0);
    check("fl_halt0", 32'(halt), 0);
    drive(1, 32'h40, 1, 0, 0);
    drive(1, 32'h41, 0, 1, 1);
    check("fl_pp_count", 32'(count), 0);
    check("fl_pp_halt", 32'(halt), 0);
    drive(1, 32'h50, 1, 0, 0);
    check("halt_not_yet", 32'(halt), 0);
    drive(0, '0, 0, 1, 0);
    check("halt_set", 32'(halt), 1);
    drive(0, '0, 0, 0, 1);
    check("halt_sticky", 32'(halt), 1);

    // asynchronous reset mid-cycle while full
    drive(1, 32'h70, 0, 0, 0);
    drive(1, 32'h71, 0, 0, 0);
    check("ar_pre_count", 32'(count), 2);
    in_valid = 0; out_ready = 0; flush = 0;
    #2 RST = 1'b1;
    sb.delete();
    #1;
    check("ar_count", 32'(count), 0);
    check("ar_valid", 32'(out_valid), 0);
    check("ar_ready", 32'(in_ready), 1);
    check("ar_halt", 32'(halt), 0);
    check("ar_data", out_data, 0);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    drive(1, 32'h60, 0, 0, 0);
    check("ar_first_data", out_data, 32'h60);
    check("ar_first_count", 32'(count), 1);
    drive(0, '0, 0, 1, 0);

`ifdef PIPEREG_PERF_EN
    drive(1, 32'h80, 0, 0, 0);
    drive(1, 32'h81, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 32'h82, 0, 0, 0);
    check("perf_stall", stall_cycles, 10);
    check("perf_hwm", 32'(occupancy_hwm), 2);
    drive(0, '0, 0, 0, 1);
    check("perf_stall_fl", stall_cycles, 10);
    check("perf_hwm_fl", 32'(occupancy_hwm), 2);
`endif

    idle();
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
